aixh_mxc_upper_repeater_pipe: RTL and testbench



---
 rtl/aixh_mxc_upper_repeater_pipe.sv | 172 +++++++++++++++++
 tb/tb_aixh_mxc_upper_repeater_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/aixh_mxc_upper_repeater_pipe.sv
// Multi-stage repeater for one MxConv upper-cell hop: a fixed-latency forward command pipe
// plus a chain of elastic two-entry backward data stages.
// Latency: forward FWD_STAGES cycles; backward BWD_STAGES cycles through an empty chain.
// Backpressure: forward has none; backward is valid/ready, full throughput,
// 2*BWD_STAGES entries of buffering, and no combinational ready path.
// Ports:
//   aixh_core_clk2x / aixh_core_rst2x : clock, synchronous active-high reset
//   i_fwd_vld/i_fwd_cmd -> o_fwd_vld/o_fwd_cmd : delayed forward command
//   i_bwd_vld/i_bwd_dat/o_bwd_rdy       : upstream side of the backward chain
//   o_bwd_vld/o_bwd_dat/i_bwd_rdy       : downstream side of the backward chain
//   o_bwd_cnt, o_idle                   : occupancy and drain status
module aixh_mxc_upper_repeater_pipe #(
   parameter int FWD_CWIDTH = 32,   // upper-cell forward command width
   parameter int BWD_DWIDTH = 32,   // upper-cell backward data width
   parameter int FWD_STAGES = 1,    // 1..8
   parameter int BWD_STAGES = 1,    // 1..8
   parameter int CNT_W      = $clog2(2*BWD_STAGES+1)
) (
   input  logic                  aixh_core_clk2x,
   input  logic                  aixh_core_rst2x,
   input  logic                  i_fwd_vld,
   input  logic [FWD_CWIDTH-1:0] i_fwd_cmd,
   output logic                  o_fwd_vld,
   output logic [FWD_CWIDTH-1:0] o_fwd_cmd,
   input  logic                  i_bwd_vld,
   input  logic [BWD_DWIDTH-1:0] i_bwd_dat,
   output logic                  o_bwd_rdy,
   output logic                  o_bwd_vld,
   output logic [BWD_DWIDTH-1:0] o_bwd_dat,
   input  logic                  i_bwd_rdy,
   output logic [CNT_W-1:0]      o_bwd_cnt,
   output logic                  o_idle
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // ---------------- forward command pipe ----------------
   logic [FWD_STAGES-1:0] fwd_vld_q;
   logic [FWD_STAGES-1:0] fwd_vld_in;
   logic [FWD_CWIDTH-1:0] fwd_cmd_q  [FWD_STAGES];
   logic [FWD_CWIDTH-1:0] fwd_cmd_in [FWD_STAGES];

   for (genvar s = 0; s < FWD_STAGES; s++) begin : g_fwd
      if (s == 0) begin : g_head
         assign fwd_vld_in[s] = i_fwd_vld;
         assign fwd_cmd_in[s] = i_fwd_cmd;
      end else begin : g_body
         assign fwd_vld_in[s] = fwd_vld_q[s-1];
         assign fwd_cmd_in[s] = fwd_cmd_q[s-1];
      end
   end

   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x) fwd_vld_q <= '0;
      else                 fwd_vld_q <= fwd_vld_in;
   end

   // Command registers are unreset and only load behind a valid, so the last
   // command stays visible on o_fwd_cmd after o_fwd_vld drops.
   always_ff @(posedge aixh_core_clk2x) begin
      for (int s = 0; s < FWD_STAGES; s++) begin
         if (fwd_vld_in[s]) fwd_cmd_q[s] <= fwd_cmd_in[s];
      end
   end

   assign o_fwd_vld = fwd_vld_q[FWD_STAGES-1];
   assign o_fwd_cmd = fwd_cmd_q[FWD_STAGES-1];

   // ---------------- backward elastic chain ----------------
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} stage_st_e;

   stage_st_e             st_q [BWD_STAGES];
   stage_st_e             st_d [BWD_STAGES];
   logic [BWD_DWIDTH-1:0] main_q [BWD_STAGES];
   logic [BWD_DWIDTH-1:0] skid_q [BWD_STAGES];
   logic [BWD_DWIDTH-1:0] dat_up [BWD_STAGES];
   logic [BWD_STAGES-1:0] vld_up, rdy_up, vld_dn, rdy_dn;
   logic [BWD_STAGES-1:0] acc, emit, main_ld, main_from_skid, skid_ld;

   for (genvar s = 0; s < BWD_STAGES; s++) begin : g_bwd
      if (s == 0) begin : g_up_ext
         assign vld_up[s] = i_bwd_vld;
         assign dat_up[s] = i_bwd_dat;
      end else begin : g_up_int
         assign vld_up[s] = vld_dn[s-1];
         assign dat_up[s] = main_q[s-1];
      end
      if (s == BWD_STAGES-1) begin : g_dn_ext
         assign rdy_dn[s] = i_bwd_rdy;
      end else begin : g_dn_int
         assign rdy_dn[s] = rdy_up[s+1];
      end
   end

   // State register and datapath registers.
   always_ff @(posedge aixh_core_clk2x) begin
      for (int s = 0; s < BWD_STAGES; s++) begin
         if (aixh_core_rst2x) st_q[s] <= ST_EMPTY;
         else                 st_q[s] <= st_d[s];
         if (main_ld[s]) main_q[s] <= main_from_skid[s] ? skid_q[s] : dat_up[s];
         if (skid_ld[s]) skid_q[s] <= dat_up[s];
      end
   end

   // Next-state logic. Main always holds the oldest entry; skid only fills
   // when main is occupied and not leaving this cycle.
   always_comb begin
      for (int s = 0; s < BWD_STAGES; s++) begin
         acc[s]            = vld_up[s] & rdy_up[s];
         emit[s]           = vld_dn[s] & rdy_dn[s];
         st_d[s]           = st_q[s];
         main_ld[s]        = 1'b0;
         main_from_skid[s] = 1'b0;
         skid_ld[s]        = 1'b0;
         case (st_q[s])
            ST_EMPTY: begin
               if (acc[s]) begin
                  st_d[s]    = ST_ONE;
                  main_ld[s] = 1'b1;
               end
            end
            ST_ONE: begin
               if (acc[s] && !emit[s]) begin
                  st_d[s]    = ST_TWO;
                  skid_ld[s] = 1'b1;
               end else if (!acc[s] && emit[s]) begin
                  st_d[s]    = ST_EMPTY;
               end else if (acc[s] && emit[s]) begin
                  main_ld[s] = 1'b1;
               end
            end
            ST_TWO: begin
               if (emit[s]) begin
                  st_d[s]           = ST_ONE;
                  main_ld[s]        = 1'b1;
                  main_from_skid[s] = 1'b1;
               end
            end
            default: st_d[s] = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs depend on state only, which breaks the ready path.
   always_comb begin
      for (int s = 0; s < BWD_STAGES; s++) begin
         rdy_up[s] = (st_q[s] != ST_TWO);
         vld_dn[s] = (st_q[s] != ST_EMPTY);
      end
   end

   assign o_bwd_rdy = rdy_up[0] & ~aixh_core_rst2x;
   assign o_bwd_vld = vld_dn[BWD_STAGES-1];
   assign o_bwd_dat = main_q[BWD_STAGES-1];

   // ---------------- occupancy / idle ----------------
   logic             bwd_acc, bwd_emit;
   logic [CNT_W-1:0] cnt_q;

   assign bwd_acc  = o_bwd_rdy & i_bwd_vld;
   assign bwd_emit = o_bwd_vld & i_bwd_rdy;

   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x)          cnt_q <= '0;
      else if (bwd_acc && !bwd_emit) cnt_q <= cnt_q + CNT_ONE;
      else if (!bwd_acc && bwd_emit) cnt_q <= cnt_q - CNT_ONE;
   end

   assign o_bwd_cnt = cnt_q;
   assign o_idle    = ~(|fwd_vld_q) & (cnt_q == '0);

endmodule

// File: tb/tb_aixh_mxc_upper_repeater_pipe.sv
// Directed and random bench for aixh_mxc_upper_repeater_pipe with a backward-data scoreboard.
module tb_aixh_mxc_upper_repeater_pipe;
   localparam int FS   = 3;
   localparam int BS   = 4;
   localparam int CW   = 8;
   localparam int DW   = 16;
   localparam int CNTW = $clog2(2*BS+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          i_fwd_vld;
   logic [CW-1:0] i_fwd_cmd;
   logic          o_fwd_vld;
   logic [CW-1:0] o_fwd_cmd;
   logic          i_bwd_vld;
   logic [DW-1:0] i_bwd_dat;
   logic          o_bwd_rdy;
   logic          o_bwd_vld;
   logic [DW-1:0] o_bwd_dat;
   logic          i_bwd_rdy;
   logic [CNTW-1:0] o_bwd_cnt;
   logic          o_idle;

   aixh_mxc_upper_repeater_pipe #(
      .FWD_CWIDTH(CW), .BWD_DWIDTH(DW), .FWD_STAGES(FS), .BWD_STAGES(BS)
   ) dut (
      .aixh_core_clk2x(clk),
      .aixh_core_rst2x(rst),
      .i_fwd_vld(i_fwd_vld),
      .i_fwd_cmd(i_fwd_cmd),
      .o_fwd_vld(o_fwd_vld),
      .o_fwd_cmd(o_fwd_cmd),
      .i_bwd_vld(i_bwd_vld),
      .i_bwd_dat(i_bwd_dat),
      .o_bwd_rdy(o_bwd_rdy),
      .o_bwd_vld(o_bwd_vld),
      .o_bwd_dat(o_bwd_dat),
      .i_bwd_rdy(i_bwd_rdy),
      .o_bwd_cnt(o_bwd_cnt),
      .o_idle(o_idle)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int cnt_ref = 0;
   int next_id = 0;
   int acc_n   = 0;
   int q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   task automatic drive(input logic v, input logic r);
      i_bwd_vld = v;
      i_bwd_rdy = r;
      i_bwd_dat = DW'(next_id);
   endtask

   // Mid-cycle sample: check occupancy, then apply this cycle's transfers to the model.
   task automatic sample();
      int want;
      @(negedge clk);
      chk("bwd_cnt", 32'(o_bwd_cnt), 32'(cnt_ref));
      if (o_bwd_vld && i_bwd_rdy) begin
         if (q.size() == 0) begin
            chk("bwd_out_without_entry", 32'(q.size()), 32'd1);
         end else begin
            want = q.pop_front();
            chk("bwd_dat", 32'(o_bwd_dat), 32'(want[DW-1:0]));
         end
         cnt_ref--;
      end
      if (o_bwd_rdy && i_bwd_vld) begin
         q.push_back(next_id);
         next_id++;
         acc_n++;
         cnt_ref++;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic bwd_cycle(input logic v, input logic r);
      drive(v, r);
      sample();
      adv();
   endtask

   task automatic drain_and_check_idle(input string tag);
      for (int k = 0; k < 4*BS+8 && q.size() > 0; k++) bwd_cycle(1'b0, 1'b1);
      chk({tag, "_drained"}, 32'(q.size()), 32'd0);
      drive(1'b0, 1'b1);
      sample();
      chk({tag, "_idle"}, 32'(o_idle), 32'd1);
      chk({tag, "_vld_low"}, 32'(o_bwd_vld), 32'd0);
      adv();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_fwd_vld = 1'b0; i_fwd_cmd = '0;
      i_bwd_vld = 1'b0; i_bwd_dat = '0; i_bwd_rdy = 1'b0;

      // Reset: ready held low while reset is asserted.
      repeat (2) begin
         @(negedge clk);
         chk("rdy_in_reset", 32'(o_bwd_rdy), 32'd0);
      end
      adv();
      rst = 1'b0;
      drive(1'b0, 1'b0);
      sample();
      chk("rst_fwd_vld", 32'(o_fwd_vld), 32'd0);
      chk("rst_bwd_vld", 32'(o_bwd_vld), 32'd0);
      chk("rst_idle",    32'(o_idle),    32'd1);
      chk("rst_rdy_after_release", 32'(o_bwd_rdy), 32'd1);
      adv();

      // Forward latency: one command, visible exactly FS cycles later, then held.
      i_fwd_vld = 1'b1; i_fwd_cmd = 8'hA5;
      for (int d = 0; d <= FS+3; d++) begin
         drive(1'b0, 1'b0);
         sample();
         chk("fwd_vld", 32'(o_fwd_vld), 32'(d == FS));
         chk("fwd_idle", 32'(o_idle), 32'(!(d >= 1 && d <= FS)));
         if (d >= FS) chk("fwd_cmd", 32'(o_fwd_cmd), 32'h0000_00A5);
         adv();
         i_fwd_vld = 1'b0; i_fwd_cmd = 8'h5A;
      end

      // Backward streaming at full throughput.
      for (int j = 0; j < 100; j++) begin
         drive(1'b1, 1'b1);
         sample();
         chk("stream_rdy", 32'(o_bwd_rdy), 32'd1);
         chk("stream_vld", 32'(o_bwd_vld), 32'(j >= BS));
         if (j >= BS) chk("stream_cnt", 32'(o_bwd_cnt), 32'(BS));
         adv();
      end
      drain_and_check_idle("stream");

      // Full stall: exactly 2*BS entries absorbed.
      acc_n = 0;
      for (int j = 0; j < 2*BS+6; j++) bwd_cycle(1'b1, 1'b0);
      chk("stall_accepts", 32'(acc_n), 32'(2*BS));
      drive(1'b1, 1'b0);
      sample();
      chk("stall_rdy", 32'(o_bwd_rdy), 32'd0);
      chk("stall_cnt", 32'(o_bwd_cnt), 32'(2*BS));
      adv();
      drain_and_check_idle("stall");

      // Simultaneous accept and emit leaves the count unchanged.
      bwd_cycle(1'b1, 1'b0);
      for (int j = 0; j < BS; j++) bwd_cycle(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      sample();
      chk("simul_pre_vld", 32'(o_bwd_vld), 32'd1);
      chk("simul_pre_cnt", 32'(o_bwd_cnt), 32'd1);
      adv();
      bwd_cycle(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      sample();
      chk("simul_cnt", 32'(o_bwd_cnt), 32'd1);
      adv();
      drain_and_check_idle("simul");

      // Random backpressure on both sides.
      for (int j = 0; j < 10000; j++)
         bwd_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain_and_check_idle("random");

      // Reset with 5 backward entries and 2 forward commands in flight.
      for (int j = 0; j < 5; j++) bwd_cycle(1'b1, 1'b0);
      i_fwd_vld = 1'b1; i_fwd_cmd = 8'h11;
      bwd_cycle(1'b0, 1'b0);
      i_fwd_cmd = 8'h22;
      bwd_cycle(1'b0, 1'b0);
      i_fwd_vld = 1'b0;
      rst = 1'b1;
      drive(1'b1, 1'b0);
      sample();
      chk("mid_rst_rdy", 32'(o_bwd_rdy), 32'd0);
      chk("mid_rst_busy", 32'(o_idle), 32'd0);
      adv();
      rst = 1'b0;
      q.delete();
      cnt_ref = 0;
      for (int j = 0; j < FS+2; j++) begin
         drive(1'b0, 1'b0);
         sample();
         chk("mid_rst_fwd_vld", 32'(o_fwd_vld), 32'd0);
         chk("mid_rst_bwd_vld", 32'(o_bwd_vld), 32'd0);
         chk("mid_rst_idle",    32'(o_idle),    32'd1);
         chk("mid_rst_rdy_after", 32'(o_bwd_rdy), 32'd1);
         adv();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
